tea_io_mailbox: RTL and testbench
=================================

# tea_io_mailbox

Byte-wide I/O peripheral on the tea_cpu I/O bus (`io_addr`/`io_rd`/`io_wr`/`io_rddata`/`io_wrdata`), providing a host-to-CPU RX FIFO and a CPU-to-host TX FIFO. The host side uses valid/ready streams. The CPU side sees memory-mapped data, status, control and scratch registers. It is the data path by which plaintext/key bytes enter and ciphertext bytes leave the TEA firmware.

## Interface
- `FIFO_DEPTH_WIDTH`, default 3: log2 of each FIFO depth (depth 8); legal range 1..3.
- `clk`  in  1  system clock, same as the CPU.
- `rst`  in  1  asynchronous, active-high reset.
- `io_addr`  in  5  register address from CPU.
- `io_rd`  in  1  CPU read strobe.
- `io_wr`  in  1  CPU write strobe.
- `io_wrdata`  in  8  CPU write data.
- `io_rddata`  out  8  read data to CPU (combinational).
- `rx_valid`  in  1  host byte valid.
- `rx_data`  in  8  host byte.
- `rx_ready`  out  1  RX FIFO can accept.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  host accepts TX byte.

## Operation
- **CPU access shape.**
  - Each CPU access holds `io_rd` or `io_wr` high for exactly 2 consecutive clocks (both CPU phases), with constant `io_addr`.
  - At least 2 idle clocks separate accesses.
  - The block acts once per access, not once per cycle.
- **Access start.** The start of an access is the rising edge of `io_rd` or `io_wr`, detected against a registered copy. At access start, `io_addr` is latched into `acc_addr_q`.
- **Register map.**
  - 0x00 RX_DATA.
    - Read returns the RX head byte.
    - The pop occurs on the clock where `io_rd` falls (`io_rd`=0, `io_rd_q`=1), using `acc_addr_q`.
    - Reading while empty returns 0x00, does not pop, and sets `rx_udf`.
  - 0x01 TX_DATA.
    - Write pushes `io_wrdata` at access start.
    - If TX is full, the byte is dropped and `tx_ovf` is set.
    - Read returns 0x00.
  - 0x02 STATUS (read-only):
    - [3:0] `rx_count` (0..8)
    - [4] `tx_full`
    - [5] `tx_empty`
    - [6] `rx_udf`
    - [7] `tx_ovf`
  - 0x03 CTRL (write-only, reads 0x00), acting at access start:
    - bit0 flushes RX
    - bit1 flushes TX
    - bit2 clears `rx_udf` and `tx_ovf`
    - Bits are independent; several may be set in one write.
  - 0x04 SCRATCH: 8-bit read/write register, written at access start.
  - 0x05-0x1F: reads 0x00, writes ignored.
- **FIFOs.**
  - Each FIFO is a circular buffer with read/write pointers of `FIFO_DEPTH_WIDTH` bits, wrapping modulo depth, plus a count of `FIFO_DEPTH_WIDTH`+1 bits.
  - `rx_ready` = !rx_full, registered from count.
  - Host push occurs when `rx_valid`&&`rx_ready`.
  - `tx_valid` = !tx_empty; `tx_data` = TX head.
  - Host pop occurs when `tx_valid`&&`tx_ready`.
- **Simultaneous events.**
  - RX push and CPU pop in the same clock: both happen; count unchanged.
  - TX CPU push and host pop in the same clock: both happen; count unchanged.
  - CPU push to a TX that was full at the start of the clock is dropped, even if the host pops the same clock.
  - Flush and push/pop in the same clock: flush wins; count becomes 0 and pointers reset to 0.
  - A sticky-flag set and a CTRL clear in the same clock: the clear wins.
- **Reset.** Reset mid-access aborts the access; the FIFOs empty. Any pending RX pop is lost.

## Timing
- Reset values:
  - FIFO pointers and counts 0, flags 0, scratch 0x00, edge registers 0.
  - `rx_ready`=1, `tx_valid`=0, `tx_data`=don't-care (drive the RAM head; the bench must not check it).
  - `io_rddata`=0x00 when `io_rd`=0.
- `io_rddata`:
  - Combinational from `io_addr` and current state while `io_rd`=1.
  - Stable across both access cycles, since the pop is deferred to the falling edge.
  - 0x00 when `io_rd`=0.
- Latencies:
  - Host RX push becomes visible in `rx_count`/RX_DATA 1 clock later.
  - CPU TX write raises `tx_valid` 1 clock after access start.
  - STATUS reflects a completed pop on the clock after the falling edge.
- No combinational path from `rx_valid` to `rx_ready`, or from `tx_ready` to `tx_valid`.
- FIFO storage is written on `posedge clk`. Head read is asynchronous (distributed RAM).

## Test plan
- **Reset/idle.** Assert `rst` mid-run.
  - Immediately: `rx_ready`=1, `tx_valid`=0.
  - After release: STATUS read = 0x20, SCRATCH read = 0x00.
- **RX fill/drain.**
  - Host pushes 0x11..0x18 (8 bytes) -> `rx_ready`=0 after the 8th, STATUS=0x28.
  - A 9th `rx_valid` is not accepted.
  - 8 CPU reads of 0x00 return 0x11..0x18 in order, each stable over both access cycles.
  - A 9th read returns 0x00 and STATUS then = 0x60.
- **TX overflow and wrap.**
  - CPU writes 0xA0..0xA8 with `tx_ready`=0 -> 8 stored, STATUS=0x90.
  - Host drains 3 with `tx_ready`=1; CPU writes 0xB0..0xB2 (pointer wrap).
  - Host then receives 0xA3..0xA7, 0xB0..0xB2.
- **Simultaneous.** With RX holding 4 bytes, a host push on the exact clock of a CPU pop (`io_rd` falling) -> `rx_count` stays 4, byte order preserved.
- **CTRL.**
  - Write 0x07 with both FIFOs non-empty and both flags set -> STATUS=0x20 next read.
  - Write 0x04 only -> flags cleared, FIFO contents intact.
- **Two-cycle strobe / unmapped addresses.** A 2-cycle `io_wr` to 0x01 pushes exactly one byte. Read of 0x1F returns 0x00. Write to 0x10 changes no state.

Source files
------------

// File: rtl/tea_io_mailbox.sv
// Byte-wide mailbox on the tea_cpu I/O bus. It holds a host-to-CPU RX FIFO, a CPU-to-host TX FIFO,
// a STATUS register, a CTRL register and a SCRATCH register. CPU accesses act once each, at the strobe edges.
module tea_io_mailbox #(
  parameter int unsigned FIFO_DEPTH_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] io_addr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_wrdata,
  output logic [7:0] io_rddata,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam int unsigned DW    = FIFO_DEPTH_WIDTH;
  localparam int unsigned DEPTH = 1 << DW;
  localparam int unsigned CW    = DW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [4:0] ADDR_RX_DATA = 5'h00;
  localparam logic [4:0] ADDR_TX_DATA = 5'h01;
  localparam logic [4:0] ADDR_STATUS  = 5'h02;
  localparam logic [4:0] ADDR_CTRL    = 5'h03;
  localparam logic [4:0] ADDR_SCRATCH = 5'h04;

  logic          io_rd_q, io_rd_d;
  logic          io_wr_q, io_wr_d;
  logic [4:0]    acc_addr_q, acc_addr_d;
  logic [7:0]    scratch_q, scratch_d;
  logic          rx_udf_q, rx_udf_d;
  logic          tx_ovf_q, tx_ovf_d;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [DW-1:0] rx_wptr_q, rx_wptr_d;
  logic [DW-1:0] rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic          rx_ready_q, rx_ready_d;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [DW-1:0] tx_wptr_q, tx_wptr_d;
  logic [DW-1:0] tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d;
  logic          tx_valid_q, tx_valid_d;

  logic rd_start_c, wr_start_c, rd_end_c;
  logic rx_empty_c, tx_empty_c, tx_full_c;
  logic rx_push_c, rx_pop_req_c, rx_pop_c, rx_flush_c;
  logic tx_push_req_c, tx_push_c, tx_pop_c, tx_flush_c;
  logic ctrl_wr_c, flag_clr_c;

  // Strobe edges and event decode
  always_comb begin
    rd_start_c    = io_rd && !io_rd_q;
    wr_start_c    = io_wr && !io_wr_q;
    rd_end_c      = !io_rd && io_rd_q;
    rx_empty_c    = (rx_count_q == '0);
    tx_empty_c    = (tx_count_q == '0);
    tx_full_c     = (tx_count_q == FULL_CNT);
    rx_push_c     = rx_valid && rx_ready_q;
    rx_pop_req_c  = rd_end_c && (acc_addr_q == ADDR_RX_DATA);
    rx_pop_c      = rx_pop_req_c && !rx_empty_c;
    tx_push_req_c = wr_start_c && (io_addr == ADDR_TX_DATA);
    tx_push_c     = tx_push_req_c && !tx_full_c;
    tx_pop_c      = tx_valid_q && tx_ready;
    ctrl_wr_c     = wr_start_c && (io_addr == ADDR_CTRL);
    rx_flush_c    = ctrl_wr_c && io_wrdata[0];
    tx_flush_c    = ctrl_wr_c && io_wrdata[1];
    flag_clr_c    = ctrl_wr_c && io_wrdata[2];
  end

  // Next state: flush and flag-clear are applied last so that they take priority
  always_comb begin
    io_rd_d    = io_rd;
    io_wr_d    = io_wr;
    acc_addr_d = acc_addr_q;
    scratch_d  = scratch_q;
    rx_udf_d   = rx_udf_q;
    tx_ovf_d   = tx_ovf_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q + CW'(rx_push_c) - CW'(rx_pop_c);
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q + CW'(tx_push_c) - CW'(tx_pop_c);

    if (rd_start_c || wr_start_c) acc_addr_d = io_addr;
    if (wr_start_c && (io_addr == ADDR_SCRATCH)) scratch_d = io_wrdata;

    if (rx_push_c) rx_wptr_d = rx_wptr_q + DW'(1);
    if (rx_pop_c)  rx_rptr_d = rx_rptr_q + DW'(1);
    if (tx_push_c) tx_wptr_d = tx_wptr_q + DW'(1);
    if (tx_pop_c)  tx_rptr_d = tx_rptr_q + DW'(1);

    if (rx_pop_req_c && rx_empty_c)  rx_udf_d = 1'b1;
    if (tx_push_req_c && tx_full_c)  tx_ovf_d = 1'b1;
    if (flag_clr_c) begin
      rx_udf_d = 1'b0;
      tx_ovf_d = 1'b0;
    end

    if (rx_flush_c) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_count_d = '0;
    end
    if (tx_flush_c) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_count_d = '0;
    end

    rx_ready_d = (rx_count_d != FULL_CNT);
    tx_valid_d = (tx_count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      acc_addr_q <= '0;
      scratch_q  <= '0;
      rx_udf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      rx_ready_q <= 1'b1;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      acc_addr_q <= acc_addr_d;
      scratch_q  <= scratch_d;
      rx_udf_q   <= rx_udf_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      rx_ready_q <= rx_ready_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // FIFO storage: unreset, because a stale entry is never visible past the count
  always_ff @(posedge clk) begin
    if (rx_push_c) rx_mem_q[rx_wptr_q] <= rx_data;
    if (tx_push_c) tx_mem_q[tx_wptr_q] <= io_wrdata;
  end

  // CPU read mux; it is steady across an access because the RX pop waits for the strobe to fall
  always_comb begin
    io_rddata = 8'h00;
    if (io_rd) begin
      case (io_addr)
        ADDR_RX_DATA: io_rddata = rx_empty_c ? 8'h00 : rx_mem_q[rx_rptr_q];
        ADDR_STATUS:  io_rddata = {tx_ovf_q, rx_udf_q, tx_empty_c, tx_full_c, 4'(rx_count_q)};
        ADDR_SCRATCH: io_rddata = scratch_q;
        default:      io_rddata = 8'h00;
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_mem_q[tx_rptr_q];

endmodule

// File: tb/tb_tea_io_mailbox.sv
// Scoreboard bench for tea_io_mailbox. The queues track the FIFO contents, and small variables track the flags and SCRATCH.
module tb_tea_io_mailbox;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] io_addr;
  logic       io_rd, io_wr;
  logic [7:0] io_wrdata, io_rddata;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_exp [$];
  logic [7:0] tx_exp [$];
  logic       m_udf, m_ovf;
  logic [7:0] m_scratch;

  tea_io_mailbox #(.FIFO_DEPTH_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wrdata(io_wrdata), .io_rddata(io_rddata), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {m_ovf, m_udf, tx_exp.size() == 0, tx_exp.size() == DEPTH, 4'(rx_exp.size())};
  endfunction

  function automatic logic [7:0] model_read(input logic [4:0] addr);
    case (addr)
      5'h00:   return (rx_exp.size() == 0) ? 8'h00 : rx_exp[0];
      5'h02:   return model_status();
      5'h04:   return m_scratch;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] addr, input logic [7:0] data);
    case (addr)
      5'h01: if (tx_exp.size() < DEPTH) tx_exp.push_back(data); else m_ovf = 1'b1;
      5'h03: begin
        if (data[0]) rx_exp.delete();
        if (data[1]) tx_exp.delete();
        if (data[2]) begin m_udf = 1'b0; m_ovf = 1'b0; end
      end
      5'h04: m_scratch = data;
      default: ;
    endcase
    io_wr = 1'b1; io_addr = addr; io_wrdata = data;
    tick();
    if (addr == 5'h01) check_eq("tx_valid_lat", 32'(tx_valid), 32'(tx_exp.size() != 0));
    tick();
    io_wr = 1'b0;
    tick();
    tick();
  endtask

  task automatic cpu_read(input logic [4:0] addr, input bit push_at_fall, input logic [7:0] pb);
    logic [7:0] exp;
    logic [7:0] tmp;
    exp = model_read(addr);
    io_rd = 1'b1; io_addr = addr;
    @(negedge clk);
    check_eq($sformatf("rd%0h_c1", addr), 32'(io_rddata), 32'(exp));
    tick();
    @(negedge clk);
    check_eq($sformatf("rd%0h_c2", addr), 32'(io_rddata), 32'(exp));
    tick();
    io_rd = 1'b0;
    if (push_at_fall) begin
      rx_valid = 1'b1; rx_data = pb;
      check_eq("sim_rdy", 32'(rx_ready), 32'(rx_exp.size() < DEPTH));
    end
    if (addr == 5'h00) begin
      if (rx_exp.size() == 0) m_udf = 1'b1;
      else tmp = rx_exp.pop_front();
    end
    if (push_at_fall) rx_exp.push_back(pb);
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic host_push(input logic [7:0] b);
    bit exp_rdy;
    exp_rdy = rx_exp.size() < DEPTH;
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    check_eq("rx_ready", 32'(rx_ready), 32'(exp_rdy));
    if (exp_rdy) rx_exp.push_back(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic host_pop();
    logic [7:0] tmp;
    tx_ready = 1'b1;
    @(negedge clk);
    check_eq("tx_valid", 32'(tx_valid), 32'(tx_exp.size() != 0));
    if (tx_exp.size() != 0) check_eq("tx_data", 32'(tx_data), 32'(tx_exp[0]));
    tick();
    if (tx_exp.size() != 0) tmp = tx_exp.pop_front();
    tx_ready = 1'b0;
  endtask

  task automatic model_reset();
    rx_exp.delete();
    tx_exp.delete();
    m_udf = 1'b0; m_ovf = 1'b0; m_scratch = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wrdata = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    model_reset();
    #1;
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_rddata", 32'(io_rddata), 32'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset in the middle of a run
    cpu_write(5'h04, 8'h5A);
    cpu_read(5'h04, 1'b0, 8'h00);
    host_push(8'h01);
    cpu_write(5'h01, 8'hEE);
    tick();
    rst = 1'b1;
    #2;
    check_eq("midrst_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("midrst_tx_valid", 32'(tx_valid), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("status_after_rst", 32'(model_status()), 32'h20);
    cpu_read(5'h04, 1'b0, 8'h00);

    // RX fill to full, reject a 9th byte, then drain past empty
    for (int i = 0; i < 8; i++) host_push(8'(8'h11 + i));
    check_eq("rx_full_ready", 32'(rx_ready), 32'd0);
    host_push(8'h99);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("status_rx_full", 32'(model_status()), 32'h28);
    for (int i = 0; i < 9; i++) cpu_read(5'h00, 1'b0, 8'h00);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("status_udf", 32'(model_status()), 32'h60);
    cpu_write(5'h03, 8'h04);
    cpu_read(5'h02, 1'b0, 8'h00);

    // TX overflow, partial drain and pointer wrap
    for (int i = 0; i < 9; i++) cpu_write(5'h01, 8'(8'hA0 + i));
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("status_tx_ovf", 32'(model_status()), 32'h90);
    for (int i = 0; i < 3; i++) host_pop();
    for (int i = 0; i < 3; i++) cpu_write(5'h01, 8'(8'hB0 + i));
    for (int i = 0; i < 8; i++) host_pop();
    @(negedge clk);
    check_eq("tx_drained", 32'(tx_valid), 32'd0);
    tick();
    cpu_write(5'h03, 8'h04);

    // Host push on the same clock as a CPU pop
    for (int i = 0; i < 4; i++) host_push(8'(8'h31 + i));
    cpu_read(5'h00, 1'b1, 8'h35);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("sim_count", 32'(model_status()), 32'h24);
    for (int i = 0; i < 4; i++) cpu_read(5'h00, 1'b0, 8'h00);

    // CTRL full clear with both FIFOs occupied and both flags set
    cpu_read(5'h00, 1'b0, 8'h00);
    host_push(8'h41);
    host_push(8'h42);
    for (int i = 0; i < 9; i++) cpu_write(5'h01, 8'(8'hD0 + i));
    cpu_read(5'h02, 1'b0, 8'h00);
    cpu_write(5'h03, 8'h07);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("ctrl7_status", 32'(model_status()), 32'h20);
    @(negedge clk);
    check_eq("ctrl7_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("ctrl7_rx_ready", 32'(rx_ready), 32'd1);
    tick();

    // Flag clear only leaves the FIFO contents intact
    cpu_read(5'h00, 1'b0, 8'h00);
    host_push(8'h77);
    for (int i = 0; i < 9; i++) cpu_write(5'h01, 8'(8'hC0 + i));
    cpu_write(5'h03, 8'h04);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("ctrl4_status", 32'(model_status()), 32'h11);
    cpu_read(5'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) host_pop();

    // One two-cycle write pushes exactly one byte; check the unmapped addresses
    cpu_write(5'h01, 8'hE5);
    cpu_read(5'h02, 1'b0, 8'h00);
    host_pop();
    @(negedge clk);
    check_eq("single_push", 32'(tx_valid), 32'd0);
    tick();
    cpu_write(5'h04, 8'h3C);
    cpu_read(5'h1F, 1'b0, 8'h00);
    cpu_read(5'h01, 1'b0, 8'h00);
    cpu_read(5'h03, 1'b0, 8'h00);
    cpu_write(5'h10, 8'hFF);
    cpu_read(5'h04, 1'b0, 8'h00);
    cpu_read(5'h02, 1'b0, 8'h00);
    check_eq("idle_rddata", 32'(io_rddata), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
